// File: rtl/seg_scan_ctrl_if.sv
// Write-side handshake between a display-content producer and seg_scan_ctrl.
interface seg_scan_ctrl_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_data;
    logic [7:0]  wr_le;
    logic [7:0]  wr_point;

    modport master (
        output wr_valid,
        output wr_data,
        output wr_le,
        output wr_point,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_data,
        input  wr_le,
        input  wr_point,
        output wr_ready
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Digit-scan and blink timing for the 8-digit seven-segment driver, with a
// one-entry write buffer whose contents are committed only on frame boundaries.
module seg_scan_ctrl #(
    parameter int unsigned SCAN_TICKS   = 100000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic           clk,
    input  logic           rstn,
    seg_scan_ctrl_if.slave wr,
    input  logic           blink_en,
    output logic [2:0]     scan,
    output logic           flash,
    output logic [31:0]    data,
    output logic [7:0]     le,
    output logic [7:0]     point,
    output logic           frame_done
);
    localparam int unsigned PRE_W = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam int unsigned FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_TICKS - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    logic [PRE_W-1:0] r_pre;
    logic [2:0]       r_scan;
    logic             r_frame_done;
    logic [FRM_W-1:0] r_frm;
    logic             r_phase;
    logic             r_flash;
    logic [31:0]      r_data;
    logic [7:0]       r_le;
    logic [7:0]       r_point;
    logic [31:0]      r_buf_data;
    logic [7:0]       r_buf_le;
    logic [7:0]       r_buf_point;
    logic             r_wr_ready;

    logic w_tick;
    logic w_boundary;
    logic w_frame_wrap;
    logic w_phase_nxt;
    logic w_accept;
    logic w_full;

    assign w_tick       = (r_pre == PRE_LAST);
    assign w_boundary   = w_tick && (r_scan == 3'd7);
    assign w_frame_wrap = (r_frm == FRM_LAST);
    assign w_phase_nxt  = r_phase ^ (w_boundary & w_frame_wrap);
    assign w_full       = ~r_wr_ready;
    assign w_accept     = wr.wr_valid & r_wr_ready;

    // Prescaler and digit scan; frame_done marks the first cycle of digit 0.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pre        <= '0;
            r_scan       <= 3'd0;
            r_frame_done <= 1'b0;
        end else begin
            r_pre        <= w_tick ? '0 : r_pre + PRE_W'(1);
            r_frame_done <= w_boundary;
            if (w_tick) begin
                r_scan <= r_scan + 3'd1;
            end
        end
    end

    // Blink phase advances per frame; flash follows blink_en without disturbing the phase.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_frm   <= '0;
            r_phase <= 1'b0;
            r_flash <= 1'b0;
        end else begin
            r_phase <= w_phase_nxt;
            r_flash <= blink_en & w_phase_nxt;
            if (w_boundary) begin
                r_frm <= w_frame_wrap ? '0 : r_frm + FRM_W'(1);
            end
        end
    end

    // One-entry buffer: a full buffer cannot accept, so commit and accept never coincide.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_buf_data  <= 32'h0;
            r_buf_le    <= 8'h00;
            r_buf_point <= 8'h00;
            r_wr_ready  <= 1'b1;
            r_data      <= 32'h0;
            r_le        <= 8'hFF;
            r_point     <= 8'h00;
        end else begin
            if (w_boundary && w_full) begin
                r_data     <= r_buf_data;
                r_le       <= r_buf_le;
                r_point    <= r_buf_point;
                r_wr_ready <= 1'b1;
            end
            if (w_accept) begin
                r_buf_data  <= wr.wr_data;
                r_buf_le    <= wr.wr_le;
                r_buf_point <= wr.wr_point;
                r_wr_ready  <= 1'b0;
            end
        end
    end

    assign scan        = r_scan;
    assign frame_done  = r_frame_done;
    assign flash       = r_flash;
    assign data        = r_data;
    assign le          = r_le;
    assign point       = r_point;
    assign wr.wr_ready = r_wr_ready;
endmodule
